inst_mem: RTL and testbench
===========================

Name: inst_mem

Overview:
- Per-PE instruction store for the PE array.
- Captures a burst of instructions streamed in while `valid` is high.
- Once the burst ends, replays the stored program continuously, one instruction per clock, in write order, wrapping to the first instruction after the last.
- Drives the PE decode stage through `inst_out`.

Parameters:
- INST_WIDTH, 64 (codebase define `INST_WIDTH`), instruction word width in bits.
- INST_DEPTH, 16, maximum number of stored instructions; must be a power of two ≥2.
- ADDR_WIDTH, log2(INST_DEPTH) = 4, pointer width.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- valid  in  1  high = `inst_in` carries an instruction to store this cycle.
- inst_in  in  INST_WIDTH  instruction word to store.
- inst_out  out  INST_WIDTH  registered instruction issued to the PE.

Interface note: one clock (`clk`); reset `rst` is asynchronous and active-low.

Behaviour:
- Reset (rst=0, asynchronous):
  - inst_out=0, wr_ptr=0, rd_ptr=0, inst_cnt=0, valid_d=0.
  - Memory array contents are not cleared; they are unreachable while inst_cnt=0.
- Internal state:
  - mem[INST_DEPTH].
  - wr_ptr (ADDR_WIDTH+1 bits).
  - inst_cnt (ADDR_WIDTH+1 bits, 0..INST_DEPTH).
  - rd_ptr (ADDR_WIDTH bits).
  - valid_d = valid delayed one clock.
- Load phase (valid=1 at edge):
  - New burst (valid=1, valid_d=0): mem[0]<=inst_in; wr_ptr<=1; inst_cnt<=1. Any previous program is discarded.
  - Continuing burst (valid=1, valid_d=1): if wr_ptr<INST_DEPTH, mem[wr_ptr]<=inst_in, wr_ptr++, inst_cnt++.
  - Continuing burst when full (wr_ptr==INST_DEPTH): the word is dropped and state is unchanged (no wrap, no overwrite).
  - inst_out<=0 and rd_ptr<=0 on every load-phase edge.
- Execute phase (valid=0 at edge):
  - If inst_cnt==0: inst_out<=0 and rd_ptr stays 0.
  - Else inst_out<=mem[rd_ptr].
  - rd_ptr advances: rd_ptr<=(rd_ptr==inst_cnt-1)?0:rd_ptr+1.
- Latency: the first edge with valid=0 after a burst of N words presents word 0 on inst_out. Word k appears k edges later. Word 0 reappears exactly N edges after its previous appearance.
- N=1: inst_out holds word 0 constantly during execute.
- Interruption: valid rising mid-replay aborts replay immediately (inst_out<=0 that edge) and starts a new program at address 0.
- Single-cycle gap inside a burst counts as two separate bursts; the second overwrites from address 0.
- Reset mid-load or mid-replay: all state returns to reset values asynchronously. After release, the block behaves as freshly powered (no program).
- Memory: single write port, single read port, read data registered into inst_out. Inferable as distributed RAM or flops.
- No X propagation on inst_out: never reads addresses ≥ inst_cnt.

Test Plan:
- Reset: hold rst=0 for 5 cycles with valid=0 → inst_out=0. Release rst=1, keep valid=0 for 4 cycles → inst_out stays 0.
- Load and replay: 5 consecutive valid=1 cycles with inst_in = 0x00000000ffff0000, …ffffaaaa, …ffffbbbb, …ffffcccc, …ffffdddd, then valid=0:
  - inst_out=0 during load.
  - First valid=0 edge gives …ffff0000, then aaaa, bbbb, cccc, dddd, then ffff0000 again (period 5), sustained ≥20 cycles.
- Reload: during replay of the above, load a 2-word burst 0x1, 0x2 → inst_out=0 during the burst, then alternates 0x1, 0x2, 0x1, …
- Overflow: 18-word burst with values 0..17 → replay cycles 0..15 only, period 16; words 16 and 17 are never output.
- Single instruction and async reset: 1-word burst 0xABCD → inst_out=0xABCD constantly. Assert rst=0 between clock edges mid-replay → inst_out=0 immediately, and stays 0 after release until a new burst is loaded and replayed.

Source files
------------

// File: rtl/inst_mem.sv
// ---------------------------------------------------------------------------
// inst_mem -- per-PE instruction store.
//
// A burst of instructions is written while `valid` is high. When `valid`
// drops, the stored program is replayed one word per clock, in write order,
// and wraps back to the first word after the last one.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous, active-low reset
//   valid     in   high = inst_in carries a word to store this cycle
//   inst_in   in   instruction word to store
//   inst_out  out  registered instruction issued to the PE decode stage
// ---------------------------------------------------------------------------
module inst_mem #(
    parameter int INST_WIDTH = 64,
    parameter int INST_DEPTH = 16,
    parameter int ADDR_WIDTH = $clog2(INST_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic [INST_WIDTH-1:0] inst_in,
    output logic [INST_WIDTH-1:0] inst_out
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH+1)'(INST_DEPTH);
    localparam logic [ADDR_WIDTH:0]   ONE_CNT   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_PTR   = ADDR_WIDTH'(1);

    logic [INST_WIDTH-1:0] mem [INST_DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   inst_cnt;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  valid_d;

    logic                  new_burst;
    logic                  room;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_waddr;
    logic [ADDR_WIDTH:0]   last_idx;
    logic                  rd_wrap;

    always_comb begin
        new_burst = valid & ~valid_d;
        // wr_ptr is one bit wider than an address so "full" is distinguishable
        room      = (wr_ptr < DEPTH_CNT);
        mem_we    = valid & (new_burst | room);
        mem_waddr = new_burst ? '0 : wr_ptr[ADDR_WIDTH-1:0];
        // Only used when inst_cnt != 0, so the subtraction never underflows
        last_idx  = inst_cnt - ONE_CNT;
        rd_wrap   = ({1'b0, rd_ptr} == last_idx);
    end

    // Storage carries no reset; words beyond inst_cnt are never read.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= inst_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_out <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inst_cnt <= '0;
            valid_d  <= 1'b0;
        end else begin
            valid_d <= valid;
            if (valid) begin
                inst_out <= '0;
                rd_ptr   <= '0;
                if (!valid_d) begin
                    // A new burst discards whatever program was stored before
                    wr_ptr   <= ONE_CNT;
                    inst_cnt <= ONE_CNT;
                end else if (room) begin
                    wr_ptr   <= wr_ptr + ONE_CNT;
                    inst_cnt <= inst_cnt + ONE_CNT;
                end
            end else if (inst_cnt == '0) begin
                inst_out <= '0;
                rd_ptr   <= '0;
            end else begin
                inst_out <= mem[rd_ptr];
                rd_ptr   <= rd_wrap ? '0 : rd_ptr + ONE_PTR;
            end
        end
    end

endmodule

// File: tb/tb_inst_mem.sv
// ---------------------------------------------------------------------------
// tb_inst_mem -- scoreboard bench for inst_mem.
// The driver applies inputs on the falling edge and, after each rising edge,
// pushes the expected inst_out computed from a program-queue model. The
// monitor pops and compares 1 time unit after every rising edge.
// ---------------------------------------------------------------------------
module tb_inst_mem;

    localparam int W     = 64;
    localparam int DEPTH = 16;

    logic         clk;
    logic         rst;
    logic         valid;
    logic [W-1:0] inst_in;
    logic [W-1:0] inst_out;

    inst_mem #(.INST_WIDTH(W), .INST_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .valid    (valid),
        .inst_in  (inst_in),
        .inst_out (inst_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    logic [W-1:0] exp_q [$];

    // Reference model: the stored program as a list of words
    logic [W-1:0] prog [$];
    bit           prev_valid = 1'b0;
    int           play_idx   = 0;

    task automatic model_reset();
        prog.delete();
        prev_valid = 1'b0;
        play_idx   = 0;
    endtask

    // Expected inst_out after a clock edge with the given sampled inputs
    task automatic model_edge(input bit r, input bit v, input logic [W-1:0] d,
                              output logic [W-1:0] e);
        if (!r) begin
            model_reset();
            e = '0;
        end else if (v) begin
            if (!prev_valid) begin
                prog.delete();
                prog.push_back(d);
            end else if (prog.size() < DEPTH) begin
                prog.push_back(d);
            end
            play_idx   = 0;
            prev_valid = 1'b1;
            e = '0;
        end else begin
            prev_valid = 1'b0;
            if (prog.size() == 0) begin
                e = '0;
            end else begin
                e = prog[play_idx];
                play_idx = (play_idx + 1) % prog.size();
            end
        end
    endtask

    task automatic step(input bit v, input logic [W-1:0] d);
        logic [W-1:0] e;
        @(negedge clk);
        valid   = v;
        inst_in = d;
        @(posedge clk);
        model_edge(rst, v, d, e);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    // Monitor
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (inst_out !== e) begin
                    errors++;
                    $display("FAIL inst_out @cycle %0d: got %h expected %h", cycle, inst_out, e);
                end
            end
        end
    end

    initial begin
        logic [W-1:0] w;
        int len;
        rst     = 1'b0;
        valid   = 1'b0;
        inst_in = '0;

        // Reset held, then released with no program
        idle(5);
        @(negedge clk);
        rst = 1'b1;
        idle(4);

        // Five-word load and replay
        step(1'b1, 64'h0000_0000_ffff_0000);
        step(1'b1, 64'h0000_0000_ffff_aaaa);
        step(1'b1, 64'h0000_0000_ffff_bbbb);
        step(1'b1, 64'h0000_0000_ffff_cccc);
        step(1'b1, 64'h0000_0000_ffff_dddd);
        idle(23);

        // Reload mid-replay with two words
        step(1'b1, 64'h1);
        step(1'b1, 64'h2);
        idle(8);

        // Overflow: 18 words, only first 16 kept
        for (int i = 0; i < 18; i++) step(1'b1, W'(i));
        idle(40);

        // Single-cycle gap splits a burst
        step(1'b1, 64'h11);
        step(1'b1, 64'h22);
        step(1'b0, '0);
        step(1'b1, 64'h33);
        idle(6);

        // Single instruction, then async reset between edges
        step(1'b1, 64'hABCD);
        idle(7);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (inst_out !== '0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0", inst_out);
        end
        model_reset();
        idle(3);
        @(negedge clk);
        rst = 1'b1;
        idle(5);
        step(1'b1, 64'h5a5a);
        step(1'b1, 64'ha5a5);
        idle(6);

        // Randomized bursts with random gaps
        for (int b = 0; b < 30; b++) begin
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                w = {$urandom, $urandom};
                step(1'b1, w);
            end
            idle($urandom_range(1, 40));
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
